// File: rtl/lsu_pkg.sv
// Shared constants and types for the LSU main-memory master.
package lsu_pkg;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } lsu_state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      logic [2:0] n;
      case (sz)
         SZ_B:    n = 3'd1;
         SZ_H:    n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake plus main-memory port of the LSU.
interface lsu_mem_master_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_error;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        mem_read_write;

   modport master (
      input  req_valid, req_write, req_size, req_unsigned,
      input  req_addr, req_wdata, mem_data_out,
      output req_ready, resp_valid, resp_error, resp_rdata,
      output mem_address, mem_data_in, mem_read_write
   );

   modport slave (
      output req_valid, req_write, req_size, req_unsigned,
      output req_addr, req_wdata, mem_data_out,
      input  req_ready, resp_valid, resp_error, resp_rdata,
      input  mem_address, mem_data_in, mem_read_write
   );

endinterface

// File: rtl/lsu_lane.sv
// Byte-lane store merge and load extract/extend, purely combinational.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        zext,
   input  logic [31:0] rbuf,
   output logic [31:0] merged,
   output logic [31:0] rdata
);

   logic [7:0]  lb;
   logic [15:0] lh;

   always_comb begin
      merged = word;
      case (size)
         SZ_B:    merged[{offset, 3'b000} +: 8] = wdata[7:0];
         SZ_H:    merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

   assign lb = rbuf[{offset, 3'b000} +: 8];
   assign lh = rbuf[{offset[1], 4'b0000} +: 16];

   always_comb begin
      rdata = rbuf;
      case (size)
         SZ_B:    rdata = {{24{~zext & lb[7]}}, lb};
         SZ_H:    rdata = {{16{~zext & lh[15]}}, lh};
         default: rdata = rbuf;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding RV32 load/store initiator for the main-memory port.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter logic [31:0] STARTING_ADDR   = 32'h01000000,
   parameter logic [31:0] MEM_DEPTH_BYTES = 32'h00100000
) (
   input  logic             clock,
   input  logic             reset,
   lsu_mem_master_if.master bus
);

   lsu_state_t  state_q;
   lsu_state_t  state_d;

   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        write_q;
   logic        zext_q;
   logic        err_q;
   logic [31:0] wdata_q;
   logic [31:0] buf_q;
   logic [31:0] addr_q;
   logic [31:0] din_q;

   logic        accept;
   logic        req_err;
   logic        bad_align;
   logic [32:0] req_end;
   logic [32:0] win_end;
   logic [31:0] merged;
   logic [31:0] ext;

   assign accept = (state_q == S_IDLE) & bus.req_valid;

   assign bad_align =
      (bus.req_size == 2'd3) |
      ((bus.req_size == SZ_H) & bus.req_addr[0]) |
      ((bus.req_size == SZ_W) & (bus.req_addr[1:0] != 2'b00));

   // 33-bit sums so an access ending at the top of the map cannot wrap
   assign req_end = {1'b0, bus.req_addr} + 33'(size_bytes(bus.req_size));
   assign win_end = {1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES};

   assign req_err = bad_align |
                    (bus.req_addr < STARTING_ADDR) |
                    (req_end > win_end);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (req_err)
                  state_d = S_RESP;
               else if (bus.req_write && bus.req_size == SZ_W)
                  state_d = S_WRITE;
               else
                  state_d = S_READ;
            end
         end
         S_READ:  state_d = write_q ? S_WRITE : S_RESP;
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         off_q   <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         zext_q  <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         buf_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
      end else begin
         if (accept) begin
            off_q   <= bus.req_addr[1:0];
            size_q  <= bus.req_size;
            write_q <= bus.req_write;
            zext_q  <= bus.req_unsigned;
            err_q   <= req_err;
            wdata_q <= bus.req_wdata;
            if (!req_err)
               addr_q <= {bus.req_addr[31:2], 2'b00};
            if (!req_err && bus.req_write && bus.req_size == SZ_W)
               din_q <= bus.req_wdata;
         end
         // Sub-word store data is merged while the read is on the bus
         if (state_q == S_READ) begin
            buf_q <= bus.mem_data_out;
            if (write_q)
               din_q <= merged;
         end
      end
   end

   lsu_lane u_lane (
      .word   (bus.mem_data_out),
      .wdata  (wdata_q),
      .size   (size_q),
      .offset (off_q),
      .zext   (zext_q),
      .rbuf   (buf_q),
      .merged (merged),
      .rdata  (ext)
   );

   assign bus.req_ready      = (state_q == S_IDLE);
   assign bus.resp_valid     = (state_q == S_RESP);
   assign bus.resp_error     = (state_q == S_RESP) & err_q;
   assign bus.resp_rdata     = (state_q == S_RESP && !err_q && !write_q)
                               ? ext : 32'h0;
   assign bus.mem_address    = addr_q;
   assign bus.mem_data_in    = din_q;
   assign bus.mem_read_write = (state_q == S_WRITE) ? WRITE : READ;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small word-array memory model.
module tb_lsu_mem_master;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int tests = 0;
   int fails = 0;

   lsu_mem_master_if bus ();

   lsu_mem_master dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // 1 KiB of backing store at the window base; other addresses read 0
   logic [31:0] mem [0:255];
   logic        hit;
   logic [7:0]  idx;

   assign hit = (bus.mem_address[31:10] == 22'h004000);
   assign idx = bus.mem_address[9:2];
   assign bus.mem_data_out = hit ? mem[idx] : 32'h0;

   always @(posedge clock)
      if (bus.mem_read_write && hit)
         mem[idx] <= bus.mem_data_in;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(
      input  logic        w,
      input  logic [1:0]  sz,
      input  logic        u,
      input  logic [31:0] a,
      input  logic [31:0] d,
      output int          lat,
      output int          waitc,
      output logic        err,
      output logic [31:0] rd,
      output logic        first_rw,
      output int          wr_cnt
   );
      bus.req_valid    = 1'b1;
      bus.req_write    = w;
      bus.req_size     = sz;
      bus.req_unsigned = u;
      bus.req_addr     = a;
      bus.req_wdata    = d;
      waitc = 0;
      while (!bus.req_ready && waitc < 10) begin
         @(negedge clock);
         waitc++;
      end
      @(posedge clock);
      #1;
      bus.req_valid    = 1'b0;
      bus.req_write    = ~w;
      bus.req_size     = 2'd3;
      bus.req_unsigned = ~u;
      bus.req_addr     = 32'hFFFF_FFFF;
      bus.req_wdata    = 32'h5A5A_5A5A;
      @(negedge clock);
      lat      = 1;
      first_rw = bus.mem_read_write;
      wr_cnt   = bus.mem_read_write ? 1 : 0;
      while (!bus.resp_valid && lat < 8) begin
         @(negedge clock);
         lat++;
         if (bus.mem_read_write) wr_cnt++;
      end
      err = bus.resp_error;
      rd  = bus.resp_rdata;
   endtask

   int          lat, waitc, wrc;
   logic        err, frw;
   logic [31:0] rd;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[64] = 32'h11223344;
      mem[66] = 32'h55667788;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;

      repeat (2) @(negedge clock);
      check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
      check("rst_rvalid", {31'b0, bus.resp_valid}, 32'd0);
      check("rst_rerr", {31'b0, bus.resp_error}, 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_rw", {31'b0, bus.mem_read_write}, 32'd0);
      check("rst_addr", bus.mem_address, 32'h0);
      check("rst_din", bus.mem_data_in, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

      do_req(1'b1, 2'd0, 1'b0, 32'h01000101, 32'h000000AB,
             lat, waitc, err, rd, frw, wrc);
      check("sb_lat", lat, 32'd3);
      check("sb_err", {31'b0, err}, 32'd0);
      check("sb_rdata", rd, 32'h0);
      check("sb_first_rw", {31'b0, frw}, 32'd0);
      check("sb_word", mem[64], 32'h1122AB44);

      mem[64] = 32'h8122AB44;
      do_req(1'b0, 2'd0, 1'b0, 32'h01000103, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lb_lat", lat, 32'd2);
      check("lb_rdata", rd, 32'hFFFFFF81);
      do_req(1'b0, 2'd0, 1'b1, 32'h01000103, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lbu_rdata", rd, 32'h00000081);
      do_req(1'b0, 2'd1, 1'b0, 32'h01000102, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lh_rdata", rd, 32'hFFFF8122);
      do_req(1'b0, 2'd1, 1'b1, 32'h01000100, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lhu_rdata", rd, 32'h0000AB44);
      do_req(1'b0, 2'd2, 1'b1, 32'h01000100, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lw_rdata", rd, 32'h8122AB44);
      check("lw_wr", wrc, 32'd0);

      do_req(1'b1, 2'd2, 1'b0, 32'h01000104, 32'hDEADBEEF,
             lat, waitc, err, rd, frw, wrc);
      check("sw_first_rw", {31'b0, frw}, 32'd1);
      check("sw_lat", lat, 32'd2);
      check("sw_err", {31'b0, err}, 32'd0);
      check("sw_word", mem[65], 32'hDEADBEEF);

      do_req(1'b1, 2'd1, 1'b0, 32'h01000101, 32'h0000FFFF,
             lat, waitc, err, rd, frw, wrc);
      check("sh_mis_err", {31'b0, err}, 32'd1);
      check("sh_mis_lat", lat, 32'd1);
      check("sh_mis_wr", wrc, 32'd0);
      check("sh_mis_rdata", rd, 32'h0);
      check("sh_mis_word", mem[64], 32'h8122AB44);
      do_req(1'b0, 2'd2, 1'b0, 32'h00000000, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lw_low_err", {31'b0, err}, 32'd1);
      check("lw_low_lat", lat, 32'd1);
      check("lw_low_wr", wrc, 32'd0);

      do_req(1'b0, 2'd2, 1'b0, 32'h010FFFFC, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lw_top_err", {31'b0, err}, 32'd0);
      check("lw_top_lat", lat, 32'd2);
      do_req(1'b0, 2'd0, 1'b0, 32'h010FFFFF, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lb_top_err", {31'b0, err}, 32'd0);
      do_req(1'b0, 2'd0, 1'b0, 32'h01100000, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lb_over_err", {31'b0, err}, 32'd1);
      do_req(1'b0, 2'd3, 1'b0, 32'h01000100, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("sz3_err", {31'b0, err}, 32'd1);
      do_req(1'b0, 2'd2, 1'b0, 32'h01000102, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("lw_mis_err", {31'b0, err}, 32'd1);

      // reset while a byte store sits in WRITE
      bus.req_valid    = 1'b1;
      bus.req_write    = 1'b1;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h01000108;
      bus.req_wdata    = 32'h000000EE;
      @(negedge clock);
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rw_in_write", {31'b0, bus.mem_read_write}, 32'd1);
      reset = 1'b1;
      #1;
      check("arst_rw", {31'b0, bus.mem_read_write}, 32'd0);
      check("arst_ready", {31'b0, bus.req_ready}, 32'd1);
      check("arst_rvalid", {31'b0, bus.resp_valid}, 32'd0);
      check("arst_addr", bus.mem_address, 32'h0);
      check("arst_din", bus.mem_data_in, 32'h0);
      check("arst_rdata", bus.resp_rdata, 32'h0);
      @(posedge clock);
      @(negedge clock);
      check("arst_word", mem[66], 32'h55667788);
      reset = 1'b0;
      @(negedge clock);
      check("arst_ready_rel", {31'b0, bus.req_ready}, 32'd1);
      check("arst_rvalid_rel", {31'b0, bus.resp_valid}, 32'd0);

      do_req(1'b1, 2'd0, 1'b0, 32'h01000100, 32'h00000001,
             lat, waitc, err, rd, frw, wrc);
      check("b2b_sb_lat", lat, 32'd3);
      do_req(1'b0, 2'd0, 1'b1, 32'h01000100, 32'h0,
             lat, waitc, err, rd, frw, wrc);
      check("b2b_wait", waitc, 32'd1);
      check("b2b_lbu", rd, 32'h00000001);
      check("b2b_word", mem[64], 32'h8122AB01);

      repeat (2) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
